// File: rtl/regfile_writeback_pkg.sv
// Shared constants for the write-back slice: register-file geometry and defaults.
package regfile_writeback_pkg;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned X0         = 0;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
endpackage

// File: rtl/regfile_writeback_sync_fifo.sv
// In-order FIFO with per-entry tag visibility so the owner can scan buffered
// destinations without popping.
module sync_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [WIDTH-1:0]                 head,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][TAG_W-1:0]      entry_tag
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr, wptr, off;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wptr] <= push_data;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    off         = '0;
    entry_valid = '0;
    entry_tag   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rptr;
      entry_valid[i] = (CW'(off) < count);
      entry_tag[i]   = mem[i][WIDTH-1 -: TAG_W];
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: arbitrates load/ALU results into an in-order buffer, drains
// one register-file write per granted cycle, and flags RAW hazards for decode.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned N     = ADDR_W,
  parameter int unsigned M     = DATA_W,
  parameter int unsigned L     = REG_COUNT,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [N-1:0]                 ld_rd,
  input  logic [M-1:0]                 ld_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [N-1:0]                 alu_rd,
  input  logic [M-1:0]                 alu_data,
  input  logic                         port_grant,
  output logic                         we3,
  output logic [N-1:0]                 a3,
  output logic [M-1:0]                 wd3,
  input  logic [N-1:0]                 q_a1,
  input  logic [N-1:0]                 q_a2,
  output logic                         haz1,
  output logic                         haz2,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  if ((L > (2 ** N)) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_check
    $error("regfile_writeback: invalid L/N/DEPTH combination");
  end

  logic                           full, empty, ld_fire, alu_fire, push;
  logic [N+M-1:0]                 push_data, head;
  logic [$clog2(DEPTH+1)-1:0]     count;
  logic [DEPTH-1:0]               entry_valid;
  logic [DEPTH-1:0][N-1:0]        entry_tag;

  assign ld_ready  = reset_n && !full;
  assign alu_ready = reset_n && !full && !ld_valid;
  assign ld_fire   = ld_valid && ld_ready;
  assign alu_fire  = alu_valid && alu_ready;
  // Writes to x0 finish the handshake but never occupy a slot.
  assign push      = (ld_fire && (ld_rd != N'(X0))) || (alu_fire && (alu_rd != N'(X0)));
  assign push_data = ld_fire ? {ld_rd, ld_data} : {alu_rd, alu_data};

  assign we3       = reset_n && !empty && port_grant;
  assign a3        = we3 ? head[N+M-1:M] : '0;
  assign wd3       = we3 ? head[M-1:0] : '0;
  assign occupancy = reset_n ? count : '0;

  sync_fifo #(
    .WIDTH (N + M),
    .DEPTH (DEPTH),
    .TAG_W (N)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push),
    .push_data   (push_data),
    .pop         (we3),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .head        (head),
    .entry_valid (entry_valid),
    .entry_tag   (entry_tag)
  );

  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_tag[i] == q_a1)) haz1 = 1'b1;
      if (entry_valid[i] && (entry_tag[i] == q_a2)) haz2 = 1'b1;
    end
    if (!reset_n || (q_a1 == N'(X0))) haz1 = 1'b0;
    if (!reset_n || (q_a2 == N'(X0))) haz2 = 1'b0;
  end
endmodule
